// File: rtl/alu_isa_pkg.sv
// Shared RV32I ALU encoding constants, imported by both the ALU control decoder and the instruction encoder.
package alu_isa_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLT = 4'b0101
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SLT = 3'b010;

  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_ZERO = 7'b0000000;

  // RV32I has no SUBI, so SUB is only legal in register form.
  function automatic logic op_is_legal(input logic [3:0] op, input logic is_imm);
    return (op <= ALU_SLT) && !((op == ALU_SUB) && is_imm);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with extra-bit pointers; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr[PW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Clear has priority over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/alu_instr_encoder.sv
// Turns ALU micro-op requests into RV32I R/I-type words: encode register E feeding an output FIFO.
module alu_instr_encoder
  import alu_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic             in_is_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_illegal,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_OCC = (PW+2)'(DEPTH);

  logic          e_valid;
  logic [31:0]   e_word;
  logic [PW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_legal;
  logic          accept;
  logic          out_fire;
  logic          fifo_push;
  logic [PW+1:0] occupancy;

  function automatic logic [31:0] encode_word(
    input logic [3:0]  op,
    input logic        is_imm,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [11:0] imm
  );
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = F3_ADD;
    f7 = F7_ZERO;
    case (op)
      ALU_ADD: f3 = F3_ADD;
      ALU_SUB: f7 = F7_SUB;
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_XOR: f3 = F3_XOR;
      ALU_SLT: f3 = F3_SLT;
      default: f3 = F3_ADD;
    endcase
    if (is_imm) return {imm, rs1, f3, rd, OPC_ITYPE};
    return {f7, rs2, rs1, f3, rd, OPC_RTYPE};
  endfunction

  assign req_legal = op_is_legal(in_alu_op, in_is_imm);
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign out_fire  = out_valid && out_ready;
  assign fifo_push = e_valid && (!fifo_full || out_fire);
  assign occupancy = (PW+2)'(fifo_count) + (PW+2)'(e_valid);
  // Capacity counts E plus FIFO so an accepted word always has a slot downstream.
  assign in_ready  = rst_n && ((occupancy < DEPTH_OCC) || out_fire);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_word  <= '0;
    end else if (flush) begin
      e_valid <= 1'b0;
    end else if (accept && req_legal) begin
      e_valid <= 1'b1;
      e_word  <= encode_word(in_alu_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm);
    end else if (fifo_push) begin
      e_valid <= 1'b0;
    end
  end

  // Illegal requests still count while flushing; dropped words never reach enc_count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_illegal   <= 1'b0;
      illegal_count <= '0;
      enc_count     <= '0;
    end else begin
      err_illegal <= accept && !req_legal;
      if (accept && !req_legal) illegal_count <= illegal_count + CNT_W'(1);
      if (fifo_push && !flush)  enc_count     <= enc_count + CNT_W'(1);
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (fifo_push),
    .pop   (out_fire),
    .wdata (e_word),
    .rdata (out_instr),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
